ifetcher_flush_ctrl: RTL and testbench

IFETCHER_FLUSH_CTRL -- requirements
Module: ifetcher_flush_ctrl

---
 rtl/ifetcher_flush_ctrl.sv | 144 ++++++++++++++
 tb/tb_ifetcher_flush_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ifetcher_flush_ctrl.sv
// Fetch flush controller: tracks outstanding fetches per channel and, on a jump,
// stalls issue, waits for drain, pulses clear, then redirects fetch to the target.
module ifetcher_flush_ctrl #(
    parameter int CW   = 4,
    parameter int NCH  = 2,
    parameter int AW   = 32,
    parameter int CLRW = 1
) (
    input  logic           iClk,
    input  logic           iReset,
    input  logic           iJumpVld,
    input  logic [AW-1:0]  iJumpPc,
    input  logic [NCH-1:0] iReqIssue,
    input  logic [NCH-1:0] iRspDone,
    output logic           oStall,
    output logic           oClear,
    output logic           oRedirectVld,
    output logic [AW-1:0]  oRedirectPc,
    output logic           oBusy,
    output logic           oErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [3:0]    CLR_LEN = 4'(CLRW);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [NCH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [AW-1:0]           target_q, target_d;
    logic                    pend_q, pend_d;
    logic [AW-1:0]           pend_pc_q, pend_pc_d;
    logic [3:0]              clr_q, clr_d;
    logic                    stall_q, clear_q, rvld_q;
    logic                    rvld_d;
    logic [AW-1:0]           rpc_q;
    logic                    drained;

    // Outstanding counters run in every state; saturation and underflow are sticky errors.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int c = 0; c < NCH; c++) begin
            if (iReqIssue[c] && !iRspDone[c]) begin
                if (cnt_q[c] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[c] = cnt_q[c] + CW'(1);
            end else if (!iReqIssue[c] && iRspDone[c]) begin
                if (cnt_q[c] == '0) err_d = 1'b1;
                else                cnt_d[c] = cnt_q[c] - CW'(1);
            end
        end
    end

    always_comb begin
        drained = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (cnt_q[c] != '0) drained = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        clr_d     = clr_q;
        case (state_q)
            IDLE: begin
                if (iJumpVld) begin
                    target_d = iJumpPc;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (iJumpVld) target_d = iJumpPc;
                if (drained) begin
                    state_d = CLEAR;
                    clr_d   = CLR_LEN;
                end
            end
            CLEAR: begin
                clr_d = clr_q - 4'd1;
                if (iJumpVld) begin
                    pend_d    = 1'b1;
                    pend_pc_d = iJumpPc;
                end
                // A jump arriving in the final clear cycle is folded in as pending.
                if (clr_q == 4'd1) begin
                    if (pend_q || iJumpVld) begin
                        state_d  = DRAIN;
                        target_d = iJumpVld ? iJumpPc : pend_pc_q;
                        pend_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rvld_d = (state_d == CLEAR) && (clr_d == 4'd1);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            target_q  <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            clr_q     <= '0;
            stall_q   <= 1'b0;
            clear_q   <= 1'b0;
            rvld_q    <= 1'b0;
            rpc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            target_q  <= target_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            clr_q     <= clr_d;
            stall_q   <= (state_d != IDLE);
            clear_q   <= (state_d == CLEAR);
            rvld_q    <= rvld_d;
            if (rvld_d) rpc_q <= target_d;
        end
    end

    assign oStall       = stall_q;
    assign oBusy        = stall_q;
    assign oClear       = clear_q;
    assign oRedirectVld = rvld_q;
    assign oRedirectPc  = rpc_q;
    assign oErr         = err_q;

endmodule

// File: tb/tb_ifetcher_flush_ctrl.sv
// Bench for ifetcher_flush_ctrl (CW=2, CLRW=3): expected redirect targets are queued
// as jumps are driven and popped when the DUT pulses oRedirectVld.
module tb_ifetcher_flush_ctrl;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          jv;
    logic [AW-1:0] jpc;
    logic [1:0]    iss, dn;
    logic          stall, clr, rvld, busy, err;
    logic [AW-1:0] rpc;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            clr_len = 0;
    logic [AW-1:0] exp_q[$];

    always #5 clk = ~clk;

    ifetcher_flush_ctrl #(.CW(2), .NCH(2), .AW(AW), .CLRW(3)) u_dut (
        .iClk(clk), .iReset(rst), .iJumpVld(jv), .iJumpPc(jpc),
        .iReqIssue(iss), .iRspDone(dn),
        .oStall(stall), .oClear(clr), .oRedirectVld(rvld), .oRedirectPc(rpc),
        .oBusy(busy), .oErr(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc && busy; i++) tick();
        chk("idle_reached", busy, 0);
    endtask

    // Scoreboard side: every redirect must match the oldest queued target, and
    // every clear burst outside reset must last exactly three cycles.
    always @(negedge clk) begin
        if (rst) begin
            clr_len = 0;
        end else begin
            if (clr) clr_len++;
            else if (clr_len != 0) begin
                chk("clr_len", clr_len, 3);
                clr_len = 0;
            end
            if (rvld) begin
                chk("rdr_with_clear", clr, 1);
                chk("rdr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("rdr_pc", rpc, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; jv = 1'b0; jpc = '0; iss = '0; dn = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_clear", clr, 0);
        chk("rst_rvld", rvld, 0);
        chk("rst_rpc", rpc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();
        chk("rel_busy", busy, 0);

        // Idle, drained jump: stall at N+1, clear N+2..N+4, idle at N+5
        jv = 1'b1; jpc = 32'h1000; exp_q.push_back(32'h1000);
        tick(); jv = 1'b0;
        chk("j1_stall", stall, 1);
        chk("j1_noclr", clr, 0);
        tick(); chk("j1_clr1", clr, 1);
        tick(); chk("j1_clr2", clr, 1); chk("j1_norvld", rvld, 0);
        tick(); chk("j1_rvld", rvld, 1); chk("j1_rpc", rpc, 32'h1000);
        tick(); chk("j1_idle", busy, 0); chk("j1_unstall", stall, 0);
        chk("j1_rpc_hold", rpc, 32'h1000);

        // Outstanding wait on ch0: 3 issues, 3 retires over 5 cycles
        iss = 2'b01; repeat (3) tick(); iss = '0;
        jv = 1'b1; jpc = 32'h2000; exp_q.push_back(32'h2000);
        tick(); jv = 1'b0;
        chk("j2_stall", stall, 1);
        for (int i = 0; i < 5; i++) begin
            dn = (i % 2 == 0) ? 2'b01 : 2'b00;
            tick();
            chk("j2_drain_noclr", clr, 0);
        end
        dn = '0;
        tick(); chk("j2_clr_after_drain", clr, 1);
        wait_idle(10);

        // Overwrite while ch1 holds 2: single flush to the latest target
        iss = 2'b10; repeat (2) tick(); iss = '0;
        jv = 1'b1; jpc = 32'h100; tick();
        jpc = 32'h200; exp_q.push_back(32'h200); tick(); jv = 1'b0;
        chk("j3_stall", stall, 1);
        dn = 2'b10; repeat (2) tick(); dn = '0;
        chk("j3_noclr", clr, 0);
        wait_idle(10);
        chk("j3_rpc", rpc, 32'h200);

        // Jump in 2nd clear cycle: old target first, then a second flush
        jv = 1'b1; jpc = 32'h3000; exp_q.push_back(32'h3000);
        tick(); jv = 1'b0;
        tick(); tick();
        jv = 1'b1; jpc = 32'h300; exp_q.push_back(32'h300);
        tick(); jv = 1'b0;
        chk("j4_rvld_old", rvld, 1); chk("j4_rpc_old", rpc, 32'h3000);
        tick(); chk("j4_redrain", stall, 1); chk("j4_redrain_noclr", clr, 0);
        wait_idle(12);
        chk("j4_rpc_new", rpc, 32'h300);

        // Jump in final clear cycle becomes pending
        jv = 1'b1; jpc = 32'h400; exp_q.push_back(32'h400);
        tick(); jv = 1'b0;
        tick(); tick(); tick();
        jv = 1'b1; jpc = 32'h500; exp_q.push_back(32'h500);
        tick(); jv = 1'b0;
        chk("j5_redrain", stall, 1); chk("j5_noclr", clr, 0);
        wait_idle(12);
        chk("j5_rpc", rpc, 32'h500);

        // Underflow on ch0: counter holds zero, error sticks
        chk("uf_err_before", err, 0);
        dn = 2'b01; tick(); dn = '0;
        chk("uf_err", err, 1);
        jv = 1'b1; jpc = 32'h600; exp_q.push_back(32'h600);
        tick(); jv = 1'b0;
        tick(); chk("uf_cnt_zero_clr", clr, 1);
        wait_idle(10);
        chk("uf_err_sticky", err, 1);

        // Reset in 2nd clear cycle aborts the flush; inputs ignored during reset
        jv = 1'b1; jpc = 32'h700; tick(); jv = 1'b0;
        tick(); tick();
        rst = 1'b1; jv = 1'b1; jpc = 32'h777;
        #1;
        chk("mr_stall", stall, 0);
        chk("mr_clear", clr, 0);
        chk("mr_rvld", rvld, 0);
        chk("mr_busy", busy, 0);
        chk("mr_err", err, 0);
        chk("mr_rpc", rpc, 0);
        tick(); tick();
        rst = 1'b0; jv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_post_busy", busy, 0);
        end

        // Overflow on ch1 with CW=2: saturates at 3, needs 3 retires to drain
        iss = 2'b10; repeat (3) tick();
        chk("ov_err_before", err, 0);
        tick(); iss = '0;
        chk("ov_err", err, 1);
        jv = 1'b1; jpc = 32'h800; exp_q.push_back(32'h800);
        tick(); jv = 1'b0;
        dn = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ov_drain_noclr", clr, 0);
        end
        dn = '0;
        tick(); chk("ov_clr", clr, 1);
        wait_idle(10);
        chk("ov_err_sticky", err, 1);

        repeat (2) tick();
        chk("rdr_all_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
